// File: rtl/wb_arb_nm_1s_if.sv
// Purpose : Wishbone B4 pipelined bundle for an N-master / 1-slave arbiter.
// Latency : n/a (signal container only).
// Backpr. : STALL/ACK/ERR travel back to masters, CYC/STB forward to the slave.
// Signal names use the arbiter's point of view: i_* are arbiter inputs and
// o_* are arbiter outputs. i_sl_* / o_sl_* face the NUM_M masters; i_m0_* /
// o_m0_* face the single slave. o_gnt is the registered one-hot grant.
// Modport slave is taken by the arbiter; modport master by whatever drives it.
interface wb_arb_nm_1s_if #(
    parameter int NUM_M = 3,
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    logic [NUM_M*ADR_W-1:0]   i_sl_adr;
    logic [NUM_M-1:0]         i_sl_cyc;
    logic [NUM_M-1:0]         i_sl_stb;
    logic [NUM_M-1:0]         i_sl_we;
    logic [NUM_M*DAT_W/8-1:0] i_sl_sel;
    logic [NUM_M*3-1:0]       i_sl_cti;
    logic [NUM_M*2-1:0]       i_sl_bte;
    logic [NUM_M*DAT_W-1:0]   i_sl_wr_dat;
    logic [NUM_M-1:0]         o_sl_stall;
    logic [NUM_M-1:0]         o_sl_ack;
    logic [NUM_M-1:0]         o_sl_err;
    logic [NUM_M*DAT_W-1:0]   o_sl_rd_dat;

    logic [ADR_W-1:0]         o_m0_adr;
    logic                     o_m0_cyc;
    logic                     o_m0_stb;
    logic                     o_m0_we;
    logic [DAT_W/8-1:0]       o_m0_sel;
    logic [2:0]               o_m0_cti;
    logic [1:0]               o_m0_bte;
    logic [DAT_W-1:0]         o_m0_wr_dat;
    logic                     i_m0_stall;
    logic                     i_m0_ack;
    logic                     i_m0_err;
    logic [DAT_W-1:0]         i_m0_rd_dat;

    logic [NUM_M-1:0]         o_gnt;

    modport slave (
        input  i_sl_adr, i_sl_cyc, i_sl_stb, i_sl_we, i_sl_sel, i_sl_cti, i_sl_bte, i_sl_wr_dat,
        output o_sl_stall, o_sl_ack, o_sl_err, o_sl_rd_dat,
        output o_m0_adr, o_m0_cyc, o_m0_stb, o_m0_we, o_m0_sel, o_m0_cti, o_m0_bte, o_m0_wr_dat,
        input  i_m0_stall, i_m0_ack, i_m0_err, i_m0_rd_dat,
        output o_gnt
    );

    modport master (
        output i_sl_adr, i_sl_cyc, i_sl_stb, i_sl_we, i_sl_sel, i_sl_cti, i_sl_bte, i_sl_wr_dat,
        input  o_sl_stall, o_sl_ack, o_sl_err, o_sl_rd_dat,
        input  o_m0_adr, o_m0_cyc, o_m0_stb, o_m0_we, o_m0_sel, o_m0_cti, o_m0_bte, o_m0_wr_dat,
        output i_m0_stall, i_m0_ack, i_m0_err, i_m0_rd_dat,
        input  o_gnt
    );
endinterface

// File: rtl/wb_arb_nm_1s.sv
// Purpose : NUM_M-master to 1-slave Wishbone B4 pipelined arbiter with burst-hold grant and watchdog.
// Latency : 1 cycle request-to-grant; data/response paths are combinational through the grant mux.
// Backpr. : granted master sees slave STALL; non-granted masters see STALL = their own CYC.
// Ports   : i_clk, i_rst_async (async, high), i_rst_sync (sync, high), i_en (0 freezes grant,
//           pointer and watchdog), io_wb (bundle, see wb_arb_nm_1s_if).
module wb_arb_nm_1s #(
    parameter int NUM_M   = 3,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int RR_EN   = 1,
    parameter int TMO_CYC = 255
) (
    input  logic           i_clk,
    input  logic           i_rst_async,
    input  logic           i_rst_sync,
    input  logic           i_en,
    wb_arb_nm_1s_if.slave  io_wb
);
    localparam int                 SEL_W    = DAT_W / 8;
    localparam int                 PTR_W    = $clog2(NUM_M);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_M - 1);
    localparam logic [15:0]        TMO_LAST = 16'(TMO_CYC - 1);

    logic [NUM_M-1:0] r_gnt;
    logic [PTR_W-1:0] r_ptr;
    logic [15:0]      r_wdog;

    logic             w_any;
    logic             w_cur_cyc;
    logic             w_rearb;
    logic             w_found;
    logic             w_tmo;
    logic             w_wdog_clr;
    logic             w_m0_cyc;
    logic             w_m0_stb;
    logic [PTR_W-1:0] w_win;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [NUM_M-1:0] w_gnt_nxt;
    int               w_idx;

    assign w_any     = |io_wb.i_sl_cyc;
    // Owner still holding CYC; also 0 when idle, so idle and "owner released" both re-arbitrate.
    assign w_cur_cyc = |(r_gnt & io_wb.i_sl_cyc);
    assign w_rearb   = ~w_cur_cyc;

    // Winner search: start at the RR pointer (or at 0 for fixed priority) and wrap explicitly,
    // so non-power-of-2 NUM_M never indexes past the last master.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int j = 0; j < NUM_M; j++) begin
            w_idx = (RR_EN != 0) ? int'(r_ptr) + j : j;
            if (w_idx >= NUM_M) w_idx = w_idx - NUM_M;
            if (!w_found && io_wb.i_sl_cyc[w_idx[PTR_W-1:0]]) begin
                w_win   = w_idx[PTR_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;

    always_comb begin
        w_gnt_nxt = r_gnt;
        if (w_rearb) w_gnt_nxt = w_any ? (NUM_M'(1) << w_win) : '0;
    end

    // Timeout is a one-cycle pulse on the last allowed count; a same-cycle ACK/ERR from the
    // slave suppresses it. Gated by i_en so a frozen counter cannot keep re-firing.
    assign w_tmo = (TMO_CYC != 0) && i_en && w_cur_cyc && (r_wdog == TMO_LAST)
                   && !io_wb.i_m0_ack && !io_wb.i_m0_err;

    assign w_wdog_clr = (w_gnt_nxt != r_gnt) || io_wb.i_m0_ack || io_wb.i_m0_err
                        || !w_cur_cyc || w_tmo || (TMO_CYC == 0);

    always_ff @(posedge i_clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            r_gnt  <= '0;
            r_ptr  <= '0;
            r_wdog <= '0;
        end else if (i_rst_sync) begin
            r_gnt  <= '0;
            r_ptr  <= '0;
            r_wdog <= '0;
        end else if (i_en) begin
            r_gnt <= w_gnt_nxt;
            if (w_rearb && w_any) r_ptr <= w_ptr_nxt;
            r_wdog <= w_wdog_clr ? '0 : r_wdog + 16'd1;
        end
    end

    // Grant mux: r_gnt is one-hot or zero, so at most one branch fires and idle leaves all zero.
    always_comb begin
        w_m0_cyc           = 1'b0;
        w_m0_stb           = 1'b0;
        io_wb.o_m0_adr     = '0;
        io_wb.o_m0_we      = 1'b0;
        io_wb.o_m0_sel     = '0;
        io_wb.o_m0_cti     = '0;
        io_wb.o_m0_bte     = '0;
        io_wb.o_m0_wr_dat  = '0;
        io_wb.o_sl_stall   = io_wb.i_sl_cyc;
        io_wb.o_sl_ack     = '0;
        io_wb.o_sl_err     = '0;
        io_wb.o_sl_rd_dat  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_gnt[i]) begin
                w_m0_cyc          = io_wb.i_sl_cyc[i];
                w_m0_stb          = io_wb.i_sl_stb[i];
                io_wb.o_m0_adr    = io_wb.i_sl_adr[i*ADR_W +: ADR_W];
                io_wb.o_m0_we     = io_wb.i_sl_we[i];
                io_wb.o_m0_sel    = io_wb.i_sl_sel[i*SEL_W +: SEL_W];
                io_wb.o_m0_cti    = io_wb.i_sl_cti[i*3 +: 3];
                io_wb.o_m0_bte    = io_wb.i_sl_bte[i*2 +: 2];
                io_wb.o_m0_wr_dat = io_wb.i_sl_wr_dat[i*DAT_W +: DAT_W];
                io_wb.o_sl_stall[i] = io_wb.i_m0_stall;
                io_wb.o_sl_ack[i]   = io_wb.i_m0_ack;
                io_wb.o_sl_err[i]   = io_wb.i_m0_err | w_tmo;
                io_wb.o_sl_rd_dat[i*DAT_W +: DAT_W] = io_wb.i_m0_rd_dat;
            end
        end
    end

    // The timeout cycle drops the slave-side strobe so the hung transfer is abandoned.
    assign io_wb.o_m0_cyc = w_m0_cyc & ~w_tmo;
    assign io_wb.o_m0_stb = w_m0_stb & ~w_tmo;
    assign io_wb.o_gnt    = r_gnt;
endmodule

// File: tb/tb_wb_arb_nm_1s.sv
// Purpose : self-checking bench for wb_arb_nm_1s (round-robin and fixed-priority instances side by side).
// Latency : reference model predicts grant one edge after each request decision.
// Backpr. : slave STALL/ACK/ERR driven directly by the bench.
module tb_wb_arb_nm_1s;
    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_async, rst_sync, en;
    logic [N-1:0]    cyc, stb, we;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] wdat;
    logic [N*SW-1:0] sel;
    logic [N*3-1:0]  cti;
    logic [N*2-1:0]  bte;
    logic            s_stall, s_ack, s_err;
    logic [DW-1:0]   s_rdat;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state per instance: index 0 = round-robin, 1 = fixed priority.
    // m_own is the owning master number or -1 when idle.
    int m_own [2];
    int m_ptr [2];
    int m_wd  [2];

    logic [2:0] t2_cyc [0:10] = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b111, 3'b111,
                                  3'b101, 3'b111, 3'b111, 3'b011, 3'b111};
    logic [2:0] t2_gnt [0:10] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                                  3'b010, 3'b100, 3'b100, 3'b100, 3'b001};

    wb_arb_nm_1s_if #(.NUM_M(N), .ADR_W(AW), .DAT_W(DW)) bus_rr ();
    wb_arb_nm_1s_if #(.NUM_M(N), .ADR_W(AW), .DAT_W(DW)) bus_fp ();

    assign bus_rr.i_sl_adr = adr;    assign bus_fp.i_sl_adr = adr;
    assign bus_rr.i_sl_cyc = cyc;    assign bus_fp.i_sl_cyc = cyc;
    assign bus_rr.i_sl_stb = stb;    assign bus_fp.i_sl_stb = stb;
    assign bus_rr.i_sl_we  = we;     assign bus_fp.i_sl_we  = we;
    assign bus_rr.i_sl_sel = sel;    assign bus_fp.i_sl_sel = sel;
    assign bus_rr.i_sl_cti = cti;    assign bus_fp.i_sl_cti = cti;
    assign bus_rr.i_sl_bte = bte;    assign bus_fp.i_sl_bte = bte;
    assign bus_rr.i_sl_wr_dat = wdat; assign bus_fp.i_sl_wr_dat = wdat;
    assign bus_rr.i_m0_stall  = s_stall; assign bus_fp.i_m0_stall  = s_stall;
    assign bus_rr.i_m0_ack    = s_ack;   assign bus_fp.i_m0_ack    = s_ack;
    assign bus_rr.i_m0_err    = s_err;   assign bus_fp.i_m0_err    = s_err;
    assign bus_rr.i_m0_rd_dat = s_rdat;  assign bus_fp.i_m0_rd_dat = s_rdat;

    wb_arb_nm_1s #(.NUM_M(N), .ADR_W(AW), .DAT_W(DW), .RR_EN(1), .TMO_CYC(TMO)) u_rr (
        .i_clk(clk), .i_rst_async(rst_async), .i_rst_sync(rst_sync), .i_en(en), .io_wb(bus_rr));
    wb_arb_nm_1s #(.NUM_M(N), .ADR_W(AW), .DAT_W(DW), .RR_EN(0), .TMO_CYC(TMO)) u_fp (
        .i_clk(clk), .i_rst_async(rst_async), .i_rst_sync(rst_sync), .i_en(en), .io_wb(bus_fp));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input int d);
        for (int j = 0; j < N; j++) begin
            int k;
            k = (d == 0) ? (m_ptr[d] + j) % N : j;
            if (cyc[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit tmo(input int d);
        int o;
        o = m_own[d];
        if (o < 0 || !en || s_ack || s_err) return 1'b0;
        return cyc[o] && (m_wd[d] == TMO - 1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1;
            m_ptr[d] = 0;
            m_wd[d]  = 0;
        end
    endtask

    task automatic check_dut(input int d);
        logic [N-1:0]    g, st, ak, er, e_g, e_st, e_ak, e_er;
        logic            c, s, w;
        logic [AW-1:0]   a;
        logic [DW-1:0]   wd;
        logic [N*DW-1:0] rd, e_rd;
        bit              t;
        int              o;
        string           p;
        if (d == 0) begin
            g = bus_rr.o_gnt; st = bus_rr.o_sl_stall; ak = bus_rr.o_sl_ack; er = bus_rr.o_sl_err;
            c = bus_rr.o_m0_cyc; s = bus_rr.o_m0_stb; w = bus_rr.o_m0_we; a = bus_rr.o_m0_adr;
            wd = bus_rr.o_m0_wr_dat; rd = bus_rr.o_sl_rd_dat; p = "rr";
        end else begin
            g = bus_fp.o_gnt; st = bus_fp.o_sl_stall; ak = bus_fp.o_sl_ack; er = bus_fp.o_sl_err;
            c = bus_fp.o_m0_cyc; s = bus_fp.o_m0_stb; w = bus_fp.o_m0_we; a = bus_fp.o_m0_adr;
            wd = bus_fp.o_m0_wr_dat; rd = bus_fp.o_sl_rd_dat; p = "fp";
        end
        o = m_own[d];
        t = tmo(d);
        e_g = '0; e_st = cyc; e_ak = '0; e_er = '0; e_rd = '0;
        if (o >= 0) begin
            e_g[o] = 1'b1;
            e_st[o] = s_stall;
            e_ak[o] = s_ack;
            e_er[o] = s_err | t;
            e_rd[o*DW +: DW] = s_rdat;
            check({p, ".m0_cyc"}, c, cyc[o] & ~t);
            check({p, ".m0_stb"}, s, stb[o] & ~t);
            check({p, ".m0_we"},  w, we[o]);
            check({p, ".m0_adr"}, a, adr[o*AW +: AW]);
            check({p, ".m0_wdat"}, wd, wdat[o*DW +: DW]);
        end else begin
            check({p, ".m0_cyc"}, c, 1'b0);
            check({p, ".m0_stb"}, s, 1'b0);
            check({p, ".m0_adr"}, a, '0);
        end
        check({p, ".gnt"},   g,  e_g);
        check({p, ".stall"}, st, e_st);
        check({p, ".ack"},   ak, e_ak);
        check({p, ".err"},   er, e_er);
        check({p, ".rdat"},  rd, e_rd);
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit t;
            int prev, nw;
            t = tmo(d);
            prev = m_own[d];
            if (rst_sync) begin
                m_own[d] = -1; m_ptr[d] = 0; m_wd[d] = 0;
            end else if (en) begin
                if (prev < 0 || !cyc[prev]) begin
                    nw = winner(d);
                    m_own[d] = nw;
                    if (nw >= 0) m_ptr[d] = (nw + 1) % N;
                end
                if (m_own[d] != prev || s_ack || s_err || prev < 0 || t) m_wd[d] = 0;
                else if (!cyc[prev]) m_wd[d] = 0;
                else m_wd[d] = m_wd[d] + 1;
            end
        end
    endtask

    // Called just after a rising edge: check mid-cycle, advance the model, move to the next edge.
    task automatic tick();
        #3;
        check_dut(0);
        check_dut(1);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic areset();
        rst_async = 1'b1;
        #1;
        model_reset();
        rst_async = 1'b0;
    endtask

    task automatic rand_data();
        logic [31:0] r;
        r = $urandom;
        adr  = {$urandom, $urandom, $urandom};
        wdat = {$urandom, $urandom, $urandom};
        sel  = r[N*SW-1:0];
        cti  = r[N*3+11:12];
        bte  = r[N*2+23:24];
        we   = r[31:29];
        s_rdat = $urandom;
    endtask

    initial begin
        bit quiet;
        rst_async = 1'b1; rst_sync = 1'b0; en = 1'b1;
        cyc = '0; stb = '0; s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0;
        rand_data();
        model_reset();

        // Reset state: grants idle, STALL mirrors CYC, no responses.
        cyc = 3'b101;
        #1;
        check("rst.gnt", bus_rr.o_gnt, 3'b000);
        check("rst.stall", bus_rr.o_sl_stall, 3'b101);
        check("rst.m0_cyc", bus_fp.o_m0_cyc, 1'b0);
        check("rst.ack", bus_fp.o_sl_ack, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst_async = 1'b0;
        cyc = '0;
        tick();

        // Fixed priority picks master 1 out of {1,2}.
        cyc = 3'b110; stb = 3'b110; rand_data();
        tick();
        #1;
        check("t1.gnt", bus_fp.o_gnt, 3'b010);
        check("t1.adr", bus_fp.o_m0_adr, adr[AW +: AW]);
        check("t1.stall2", bus_fp.o_sl_stall[2], 1'b1);
        tick();
        cyc = '0; stb = '0;
        tick();

        // Round-robin rotation with back-to-back owners.
        areset();
        s_ack = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            cyc = t2_cyc[i]; stb = cyc; rand_data();
            #1;
            check("t2.gnt", bus_rr.o_gnt, t2_gnt[i]);
            tick();
        end

        // Burst is never split by a higher-priority request.
        areset();
        cyc = 3'b100; stb = 3'b100;
        tick();
        for (int i = 0; i < 4; i++) begin
            cyc = 3'b101; rand_data();
            #1;
            check("t3.gnt_rr", bus_rr.o_gnt, 3'b100);
            check("t3.gnt_fp", bus_fp.o_gnt, 3'b100);
            tick();
        end
        cyc = 3'b001;
        #1;
        check("t3.hold", bus_fp.o_gnt, 3'b100);
        tick();
        #1;
        check("t3.next", bus_fp.o_gnt, 3'b001);
        tick();

        // Watchdog: silent slave -> ERR and dropped CYC on the 8th granted cycle only.
        areset();
        s_ack = 1'b0; cyc = 3'b001; stb = 3'b001;
        tick();
        for (int g = 1; g <= 9; g++) begin
            rand_data();
            #1;
            check("t4.err", bus_rr.o_sl_err[0], (g == 8));
            check("t4.m0_cyc", bus_rr.o_m0_cyc, (g != 8));
            tick();
        end
        // Same, but an ACK lands on the 8th cycle and wins over the timeout.
        areset();
        tick();
        for (int g = 1; g <= 9; g++) begin
            s_ack = (g == 8);
            #1;
            check("t4a.err", bus_rr.o_sl_err[0], 1'b0);
            check("t4a.m0_cyc", bus_rr.o_m0_cyc, 1'b1);
            tick();
        end

        // Async reset mid-burst, then master 0 wins a 3-way tie.
        areset();
        s_ack = 1'b1; cyc = 3'b010; stb = 3'b010;
        tick();
        tick();
        #1;
        check("t5.pre", bus_rr.o_gnt, 3'b010);
        rst_async = 1'b1;
        #1;
        check("t5.gnt", bus_rr.o_gnt, 3'b000);
        check("t5.m0_cyc", bus_rr.o_m0_cyc, 1'b0);
        model_reset();
        rst_async = 1'b0;
        cyc = 3'b111;
        tick();
        #1;
        check("t5.tie", bus_rr.o_gnt, 3'b001);
        tick();

        // Sync reset mid-burst drops the grant at the next edge without an ERR.
        areset();
        s_ack = 1'b0; cyc = 3'b010;
        tick();
        tick();
        rst_sync = 1'b1;
        tick();
        rst_sync = 1'b0;
        #1;
        check("srst.gnt", bus_rr.o_gnt, 3'b000);
        check("srst.err", bus_rr.o_sl_err, 3'b000);
        tick();

        // EN=0 freezes arbitration while idle.
        areset();
        en = 1'b0; cyc = 3'b010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6.gnt", bus_rr.o_gnt, 3'b000);
            check("t6.stall1", bus_rr.o_sl_stall[1], 1'b1);
            tick();
        end
        en = 1'b1;
        tick();
        #1;
        check("t6.gnt_en", bus_rr.o_gnt, 3'b010);
        tick();

        // Randomized traffic against the reference model.
        areset();
        quiet = 1'b0;
        cyc = '0;
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) cyc[i] = ~cyc[i];
            rand_data();
            stb = cyc & 3'($urandom);
            if ($urandom_range(0, 40) == 0) quiet = ~quiet;
            s_ack   = quiet ? 1'b0 : ($urandom_range(0, 2) == 0);
            s_err   = ($urandom_range(0, 40) == 0);
            s_stall = 1'($urandom);
            en      = ($urandom_range(0, 9) != 0);
            rst_sync = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 300) == 0) areset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
